// File: rtl/q_rr_arbiter_pkg.sv
// Shared helpers for round-robin scheduling blocks.
// Pure functions only; no latency and no flow control.
package q_rr_arbiter_pkg;

   // Index increment with explicit wrap, so non-power-of-2 counts stay in range.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/q_rr_arbiter_pick.sv
// Circular priority picker: the first set request at or after rr_ptr, wrapping around.
// Combinational (0 cycles); this block has no flow control of its own.
module rr_pick #(
   parameter int NUM_REQ     = 4,
   parameter int LOG_NUM_REQ = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]     req,
   input  logic [LOG_NUM_REQ-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]     grant,
   output logic [LOG_NUM_REQ-1:0] grant_idx,
   output logic                   any
);

   logic [2*NUM_REQ-1:0] dbl_req;
   logic [2*NUM_REQ-1:0] ptr_mask;
   logic [2*NUM_REQ-1:0] masked;

   // Lower copy is masked below rr_ptr; the upper copy supplies the wrapped part of the scan.
   always_comb begin
      dbl_req = {req, req};
      for (int i = 0; i < 2*NUM_REQ; i++) begin
         ptr_mask[i] = (i >= int'(rr_ptr));
      end
      masked = dbl_req & ptr_mask;
   end

   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      for (int i = 0; i < 2*NUM_REQ; i++) begin
         if (!any && masked[i]) begin
            any       = 1'b1;
            grant_idx = (i >= NUM_REQ) ? LOG_NUM_REQ'(i - NUM_REQ) : LOG_NUM_REQ'(i);
         end
      end
      grant = any ? (NUM_REQ'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/q_rr_arbiter.sv
// Round-robin merge of NUM_REQ ready/valid producers into one registered output stage, tagged with the source ID.
// Latency is 1 cycle. Under output backpressure every req_ready is 0, and the held beat stays stable.
module q_rr_arbiter
   import q_rr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REQ     = 4,
   parameter int LOG_NUM_REQ = $clog2(NUM_REQ)
) (
   input  logic                                CLK,
   input  logic                                nRST,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic                                out_valid,
   output logic [DATA_WIDTH-1:0]               out_data,
   output logic [LOG_NUM_REQ-1:0]              out_id,
   input  logic                                out_ready
);

   logic [LOG_NUM_REQ-1:0] rr_ptr;
   logic [LOG_NUM_REQ-1:0] grant_idx;
   logic [NUM_REQ-1:0]     grant;
   logic                   any_req;
   logic                   load_ok;
   logic                   load;

   rr_pick #(
      .NUM_REQ     (NUM_REQ),
      .LOG_NUM_REQ (LOG_NUM_REQ)
   ) u_pick (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   assign load_ok = ~out_valid | out_ready;
   assign load    = load_ok & any_req;
   // No grant can complete while reset is held, so ready is suppressed too.
   assign req_ready = (nRST & load) ? grant : '0;

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         rr_ptr    <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= req_data[grant_idx];
         out_id    <= grant_idx;
         rr_ptr    <= LOG_NUM_REQ'(wrap_inc(32'(grant_idx), NUM_REQ));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_q_rr_arbiter.sv
// Scoreboard bench for q_rr_arbiter: a random producer model plus a circular-scan reference, and a directed NUM_REQ=3 instance.
module tb_q_rr_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int LW = 2;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   logic nRST3 = 1'b0;
   always #5 CLK = ~CLK;

   logic [N-1:0]        req_valid;
   logic [N-1:0][W-1:0] req_data;
   logic [N-1:0]        req_ready;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic [LW-1:0]       out_id;
   logic                out_ready;

   logic [2:0]          req_valid3;
   logic [2:0][W-1:0]   req_data3;
   logic [2:0]          req_ready3;
   logic                out_valid3;
   logic [W-1:0]        out_data3;
   logic [1:0]          out_id3;
   logic                out_ready3;

   q_rr_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) u_dut (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready));

   q_rr_arbiter #(.DATA_WIDTH(W), .NUM_REQ(3)) u_dut3 (
      .CLK(CLK), .nRST(nRST3), .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_id(out_id3), .out_ready(out_ready3));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {int id; logic [W-1:0] data;} beat_t;
   beat_t exp_q[$];

   // Reference state: what the output stage holds and where priority starts.
   int           m_ptr;
   bit           m_ov;
   bit           chk_en = 0;
   logic [N-1:0] exp_rdy;
   bit           exp_ov;

   // Producer model: each requester holds a beat until it is accepted.
   bit           pend[N];
   logic [W-1:0] pdata[N];
   logic [N-1:0] acc_last = '0;
   logic [N-1:0] en_mask = '1;
   int           p_valid = 100;
   int           p_ordy = 100;
   bit           fixed_data = 1;
   int           seq = 0;
   bit           t5_done = 0;

   task automatic drive_and_model();
      bit load_ok;
      int win;
      for (int i = 0; i < N; i++) begin
         if (acc_last[i]) pend[i] = 0;
         if (!pend[i] && $urandom_range(99) < p_valid) begin
            pend[i]  = 1;
            pdata[i] = fixed_data ? W'(i * 32'h11) : {8'(i), 24'(seq)};
            seq++;
         end
         req_valid[i] = pend[i] && en_mask[i];
         req_data[i]  = pdata[i];
      end
      out_ready = ($urandom_range(99) < p_ordy);
      load_ok = !m_ov || out_ready;
      win = -1;
      for (int k = 0; k < N; k++) begin
         if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_ov  = m_ov;
      exp_rdy = '0;
      if (load_ok && win >= 0) begin
         exp_rdy[win] = 1'b1;
         exp_q.push_back('{win, req_data[win]});
         m_ov  = 1;
         m_ptr = (win + 1) % N;
      end else if (out_ready) begin
         m_ov = 0;
      end
      acc_last = exp_rdy;
      chk_en   = 1;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      drive_and_model();
   endtask

   task automatic apply_reset();
      nRST = 1'b0;
      exp_q.delete();
      m_ptr    = 0;
      m_ov     = 0;
      acc_last = '0;
      chk_en   = 0;
   endtask

   task automatic release_reset();
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      drive_and_model();
   endtask

   // Monitor: ready/valid against the reference, the scoreboard pop on every consumed beat, stability, and starvation.
   initial begin
      bit           prev_stall;
      logic [W-1:0] prev_data;
      logic [LW-1:0] prev_id;
      int           waits[N];
      beat_t        mb;
      prev_stall = 0;
      prev_data  = '0;
      prev_id    = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      forever begin
         @(negedge CLK);
         if (!nRST || !chk_en) begin
            prev_stall = 0;
            for (int i = 0; i < N; i++) waits[i] = 0;
         end else begin
            chk("req_ready", req_ready, exp_rdy);
            chk("out_valid", out_valid, exp_ov);
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_data);
               chk("stall_id", out_id, prev_id);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", out_id, out_data);
               end else begin
                  mb = exp_q.pop_front();
                  chk("out_id", out_id, mb.id);
                  chk("out_data", out_data, mb.data);
               end
            end
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  chk("starvation_bound", waits[i] <= N - 1, 1);
                  waits[i] = 0;
               end else if (req_valid[i] && (req_valid & req_ready) != '0) begin
                  waits[i]++;
               end else if (!req_valid[i]) begin
                  waits[i] = 0;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_id    = out_id;
         end
      end
   end

   // NUM_REQ=3 instance: the pointer must wrap 2 -> 0 and never reach 3.
   initial begin
      logic [2:0] exp5;
      int         exp_id;
      req_valid3 = '0;
      out_ready3 = 1'b1;
      for (int j = 0; j < 3; j++) req_data3[j] = 32'hA0 + j;
      repeat (2) @(posedge CLK);
      #1;
      nRST3 = 1'b1;
      req_valid3 = 3'b010;
      @(negedge CLK);
      chk("t5_ready_first", req_ready3, 3'b010);
      @(posedge CLK);
      #1;
      req_valid3 = 3'b101;
      exp5   = 3'b100;
      exp_id = 1;
      for (int j = 0; j < 6; j++) begin
         @(negedge CLK);
         chk("t5_ready", req_ready3, exp5);
         chk("t5_out_id", out_id3, exp_id);
         chk("t5_out_data", out_data3, 32'hA0 + exp_id);
         chk("t5_ptr_range", u_dut3.rr_ptr < 2'd3, 1);
         exp_id = (exp5 == 3'b100) ? 2 : 0;
         exp5   = (exp5 == 3'b100) ? 3'b001 : 3'b100;
         @(posedge CLK);
      end
      t5_done = 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bit seen;
      for (int i = 0; i < N; i++) begin
         pend[i]  = 0;
         pdata[i] = '0;
      end
      // 1: reset holds with every request valid
      apply_reset();
      req_valid = '1;
      req_data  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("t1_rst_out_valid", out_valid, 0);
      chk("t1_rst_out_id", out_id, 0);
      chk("t1_rst_out_data", out_data, 0);
      chk("t1_rst_req_ready", req_ready, 4'b0000);
      release_reset();
      @(negedge CLK);
      chk("t1_first_grant", req_ready, 4'b0001);

      // 2: all valid, no backpressure, fixed data
      repeat (12) step();

      // 3: only requester 2 valid
      en_mask = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         step();
         @(negedge CLK);
         chk("t3_ready", req_ready, 4'b0100);
         if (i > 0) begin
            chk("t3_out_id", out_id, 2);
            chk("t3_no_bubble", out_valid, 1);
         end
      end

      // 4: stall with out_id=1 held, then resume from requester 2
      #1;
      apply_reset();
      en_mask = '1;
      release_reset();
      step();
      p_ordy = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge CLK);
         chk("t4_stall_ready", req_ready, 4'b0000);
         chk("t4_stall_id", out_id, 1);
      end
      p_ordy = 100;
      step();
      @(negedge CLK);
      chk("t4_resume_ready", req_ready, 4'b0100);
      step();
      @(negedge CLK);
      chk("t4_resume_id", out_id, 2);

      // Random traffic
      fixed_data = 0;
      p_valid    = 60;
      p_ordy     = 70;
      repeat (1500) step();

      // 6: async reset between edges while a beat is held
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         step();
         @(negedge CLK);
         seen = out_valid;
      end
      chk("t6_found_held_beat", seen, 1);
      #2;
      apply_reset();
      #1;
      chk("t6_async_out_valid", out_valid, 0);
      chk("t6_async_req_ready", req_ready, 4'b0000);
      chk("t6_async_out_id", out_id, 0);
      repeat (2) @(posedge CLK);
      release_reset();
      repeat (300) step();

      // Drain: everything accepted must have come out
      p_valid = 0;
      p_ordy  = 100;
      repeat (12) step();
      @(negedge CLK);
      chk("drain_queue_empty", exp_q.size(), 0);

      for (int k = 0; k < 200 && !t5_done; k++) @(posedge CLK);
      chk("t5_completed", t5_done, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
